// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle main control unit: opcodes, functs,
// FSM states and the datapath select fields.
package control_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_NANDI  = 6'b010000;
  localparam logic [5:0] OP_BGTZAL = 6'b100001;
  localparam logic [5:0] OP_BALV   = 6'b100000;
  localparam logic [5:0] OP_JRSAL  = 6'b010001;

  localparam logic [5:0] FN_JMNOR  = 6'b100111;
  localparam logic [5:0] FN_BRNV   = 6'b010101;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_NANDI,
    ALU_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    LINK,
    JR_RD,
    JR_WR
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_NAND  = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10,
    RD_RS = 2'b11
  } regdst_t;

  // All datapath strobes for one cycle, so a fault or reset can clear them at once.
  typedef struct packed {
    logic    iord;
    logic    irwrite;
    logic    pcwrite;
    logic    pcwritecond;
    logic    alusrca;
    logic    memtoreg;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    statusregwrite;
    pcsrc_t  pcsource;
    srcb_t   alusrcb;
    aluop_t  aluop;
    regdst_t regdst;
  } ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit and the IR / status register / datapath.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             cond_v;
  logic             cond_gtz;
  logic             mem_ready;

  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             ALUSrcA;
  logic             MemToReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             StatusRegWrite;
  logic [1:0]       PCSource;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       RegDst;

  logic             bus_error;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  opcode, funct, cond_v, cond_gtz, mem_ready,
    output IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcA, MemToReg, RegWrite,
           MemRead, MemWrite, StatusRegWrite, PCSource, ALUSrcB, ALUOp, RegDst,
           bus_error, illegal, instr_count, cycle_count
  );

  modport slave (
    output opcode, funct, cond_v, cond_gtz, mem_ready,
    input  IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcA, MemToReg, RegWrite,
           MemRead, MemWrite, StatusRegWrite, PCSource, ALUSrcB, ALUOp, RegDst,
           bus_error, illegal, instr_count, cycle_count
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired is high once MEM_TIMEOUT
// cycles have elapsed since the last clear.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic expired
);
  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(MEM_TIMEOUT));

  // Saturates so a long stay in a non-memory state can never wrap it.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM with memory ready/timeout handshake and
// retired-instruction / cycle performance counters.
module multicycle_control
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  state_t           state_q, state_d;
  ctl_t             ctl;
  logic             retire, timeout, bad_op;
  logic             expired, tmr_clr;
  logic             is_balv, take;
  logic [CNT_W-1:0] instr_q, cycle_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .expired (expired)
  );

  assign is_balv = (bus.opcode == OP_BALV);
  assign take    = is_balv ? bus.cond_v : bus.cond_gtz;

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    retire  = 1'b0;
    timeout = 1'b0;
    bad_op  = 1'b0;
    case (state_q)
      FETCH: begin
        ctl.memread = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          ctl.irwrite = 1'b1;
          ctl.pcwrite = 1'b1;
          state_d     = DECODE;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      DECODE: begin
        ctl.alusrcb = SRCB_IMMSH;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JMNOR)     state_d = JR_RD;
            else if (bus.funct == FN_BRNV) state_d = BRANCH;
            else                           state_d = EXEC_R;
          end
          OP_NANDI:          state_d = EXEC_NANDI;
          OP_LW, OP_SW:      state_d = MEM_ADDR;
          OP_BEQ:            state_d = BRANCH;
          OP_BALV, OP_BGTZAL: state_d = LINK;
          OP_JRSAL:          state_d = JR_RD;
          default: begin
            bad_op  = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALU_FUNCT;
        state_d     = ALU_WB;
      end
      EXEC_NANDI: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALU_NAND;
        state_d     = ALU_WB;
      end
      // ALU inputs are held from the execute cycle so the status flags stay valid.
      ALU_WB: begin
        ctl.alusrca  = 1'b1;
        ctl.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
        if (bus.opcode == OP_NANDI) begin
          ctl.alusrcb = SRCB_IMM;
          ctl.aluop   = ALU_NAND;
          ctl.regdst  = RD_RT;
        end else begin
          ctl.aluop          = ALU_FUNCT;
          ctl.regdst         = RD_RD;
          ctl.statusregwrite = 1'b1;
        end
      end
      MEM_ADDR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        state_d     = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctl.iord    = 1'b1;
        ctl.memread = 1'b1;
        if (bus.mem_ready)  state_d = MEM_WB;
        else if (expired)   timeout = 1'b1;
      end
      MEM_WB: begin
        ctl.regdst   = RD_RT;
        ctl.memtoreg = 1'b1;
        ctl.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      BRANCH: begin
        ctl.alusrca  = 1'b1;
        ctl.pcsource = PC_ALUOUT;
        retire       = 1'b1;
        state_d      = FETCH;
        if (bus.opcode == OP_BEQ) begin
          ctl.aluop       = ALU_SUB;
          ctl.pcwritecond = 1'b1;
        end else begin
          ctl.pcwrite = ~bus.cond_v;
        end
      end
      LINK: begin
        ctl.regdst   = is_balv ? RD_RA : RD_RS;
        ctl.regwrite = take;
        ctl.pcwrite  = take;
        ctl.pcsource = PC_ALUOUT;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      JR_RD: begin
        ctl.iord    = 1'b1;
        ctl.memread = 1'b1;
        if (bus.mem_ready)  state_d = JR_WR;
        else if (expired)   timeout = 1'b1;
      end
      JR_WR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
        ctl.pcsource = PC_REG;
        if (bus.opcode == OP_RTYPE) begin
          ctl.regdst   = RD_RA;
          ctl.regwrite = 1'b1;
        end
        if (bus.mem_ready) begin
          ctl.pcwrite = 1'b1;
          retire      = 1'b1;
          state_d     = FETCH;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase

    if (timeout) begin
      ctl     = '0;
      state_d = FETCH;
    end
    if (reset) begin
      ctl = '0;
    end
  end

  // A timeout in FETCH re-enters FETCH, so it must clear the wait counter too.
  assign tmr_clr = (state_d != state_q) || timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign bus.IorD           = ctl.iord;
  assign bus.IRWrite        = ctl.irwrite;
  assign bus.PCWrite        = ctl.pcwrite;
  assign bus.PCWriteCond    = ctl.pcwritecond;
  assign bus.ALUSrcA        = ctl.alusrca;
  assign bus.MemToReg       = ctl.memtoreg;
  assign bus.RegWrite       = ctl.regwrite;
  assign bus.MemRead        = ctl.memread;
  assign bus.MemWrite       = ctl.memwrite;
  assign bus.StatusRegWrite = ctl.statusregwrite;
  assign bus.PCSource       = ctl.pcsource;
  assign bus.ALUSrcB        = ctl.alusrcb;
  assign bus.ALUOp          = ctl.aluop;
  assign bus.RegDst         = ctl.regdst;
  assign bus.bus_error      = timeout & ~reset;
  assign bus.illegal        = bad_op & ~reset;
  assign bus.instr_count    = instr_q;
  assign bus.cycle_count    = cycle_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MEM_TIMEOUT=4 and CNT_W=4.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  multicycle_control_if #(.CNT_W(4)) bus ();

  multicycle_control #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [19:0] all_out;
  assign all_out = {bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCWriteCond, bus.ALUSrcA,
                    bus.MemToReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
                    bus.StatusRegWrite, bus.PCSource, bus.ALUSrcB, bus.ALUOp,
                    bus.RegDst, bus.bus_error, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH with ready high, then DECODE; leaves the bench one cycle into execute.
  task automatic fd(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_memread", bus.MemRead, 1);
    chk("fetch_irwrite", bus.IRWrite, 1);
    tick();
    chk("decode_srcb", bus.ALUSrcB, 2'b11);
    chk("decode_legal", bus.illegal, 0);
    tick();
  endtask

  task automatic cnts(input string tag, input logic [3:0] ei, input logic [3:0] ec);
    chk({tag, "_instr"}, bus.instr_count, ei);
    chk({tag, "_cycle"}, bus.cycle_count, ec);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b100000;
    bus.mem_ready = 1'b1;
    bus.cond_v    = 1'b0;
    bus.cond_gtz  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reset_strobes", all_out, 0);
      tick();
    end
    reset = 1'b0;
    #1;

    // R-type: 4 cycles
    chk("r_fetch_memread", bus.MemRead, 1);
    chk("r_fetch_iord", bus.IorD, 0);
    chk("r_fetch_srcb", bus.ALUSrcB, 2'b01);
    chk("r_fetch_pcwrite", bus.PCWrite, 1);
    cnts("r_start", 0, 0);
    tick();
    chk("r_decode_srcb", bus.ALUSrcB, 2'b11);
    tick();
    chk("r_exec_aluop", bus.ALUOp, 2'b10);
    chk("r_exec_srca", bus.ALUSrcA, 1);
    tick();
    chk("r_wb_regwrite", bus.RegWrite, 1);
    chk("r_wb_srw", bus.StatusRegWrite, 1);
    chk("r_wb_regdst", bus.RegDst, 2'b01);
    tick();
    cnts("r_end", 1, 4);

    // lw with three not-ready cycles in MEM_RD: 8 cycles
    fd(6'b100011, 6'b000000);
    chk("lw_addr_srcb", bus.ALUSrcB, 2'b10);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_memread", bus.MemRead, 1);
      chk("lw_wait_iord", bus.IorD, 1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_ready_memread", bus.MemRead, 1);
    tick();
    chk("lw_wb_memtoreg", bus.MemToReg, 1);
    chk("lw_wb_regwrite", bus.RegWrite, 1);
    tick();
    cnts("lw_end", 2, 12);

    // balv not taken, then taken
    bus.cond_v = 1'b0;
    fd(6'b100000, 6'b000000);
    chk("balv0_regwrite", bus.RegWrite, 0);
    chk("balv0_pcwrite", bus.PCWrite, 0);
    tick();
    cnts("balv0_end", 3, 15);
    bus.cond_v = 1'b1;
    fd(6'b100000, 6'b000000);
    chk("balv1_regdst", bus.RegDst, 2'b10);
    chk("balv1_regwrite", bus.RegWrite, 1);
    chk("balv1_pcwrite", bus.PCWrite, 1);
    chk("balv1_pcsrc", bus.PCSource, 2'b01);
    tick();
    cnts("balv1_end", 4, 2);
    bus.cond_v = 1'b0;

    bus.cond_gtz = 1'b1;
    fd(6'b100001, 6'b000000);
    chk("bgtzal_regdst", bus.RegDst, 2'b11);
    chk("bgtzal_regwrite", bus.RegWrite, 1);
    tick();
    cnts("bgtzal_end", 5, 5);
    bus.cond_gtz = 1'b0;

    // sw, memory never ready: 4 write cycles then bus_error
    fd(6'b101011, 6'b000000);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("swto_memwrite", bus.MemWrite, 1);
      chk("swto_no_err", bus.bus_error, 0);
      tick();
    end
    #1;
    chk("swto_bus_error", bus.bus_error, 1);
    chk("swto_dropped", bus.MemWrite, 0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("swto_err_pulse", bus.bus_error, 0);
    chk("swto_back_fetch", bus.MemRead, 1);
    cnts("swto_end", 5, 13);

    // sw, ready arrives in the cycle the timeout expires
    fd(6'b101011, 6'b000000);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("swedge_memwrite", bus.MemWrite, 1);
    chk("swedge_no_err", bus.bus_error, 0);
    tick();
    cnts("swedge_end", 6, 5);

    // illegal opcode
    bus.opcode = 6'b111111;
    #1;
    tick();
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_no_regwrite", bus.RegWrite, 0);
    chk("ill_no_memwrite", bus.MemWrite, 0);
    chk("ill_no_pcwrite", bus.PCWrite, 0);
    tick();
    chk("ill_pulse_end", bus.illegal, 0);
    chk("ill_back_fetch", bus.MemRead, 1);
    cnts("ill_end", 6, 7);

    // jrsal
    fd(6'b010001, 6'b000000);
    chk("jrsal_rd_memread", bus.MemRead, 1);
    chk("jrsal_rd_iord", bus.IorD, 1);
    tick();
    chk("jrsal_wr_memwrite", bus.MemWrite, 1);
    chk("jrsal_wr_pcsrc", bus.PCSource, 2'b11);
    chk("jrsal_wr_pcwrite", bus.PCWrite, 1);
    chk("jrsal_wr_noreg", bus.RegWrite, 0);
    tick();
    cnts("jrsal_end", 7, 11);

    // jmnor
    fd(6'b000000, 6'b100111);
    tick();
    chk("jmnor_regdst", bus.RegDst, 2'b10);
    chk("jmnor_regwrite", bus.RegWrite, 1);
    chk("jmnor_memwrite", bus.MemWrite, 1);
    tick();
    cnts("jmnor_end", 8, 15);

    // brnv taken (no overflow)
    fd(6'b000000, 6'b010101);
    chk("brnv_pcwrite", bus.PCWrite, 1);
    chk("brnv_pcsrc", bus.PCSource, 2'b01);
    chk("brnv_no_cond", bus.PCWriteCond, 0);
    tick();
    cnts("brnv_end", 9, 2);

    // nandi
    fd(6'b010000, 6'b000000);
    chk("nandi_aluop", bus.ALUOp, 2'b11);
    tick();
    chk("nandi_regwrite", bus.RegWrite, 1);
    chk("nandi_regdst", bus.RegDst, 2'b00);
    tick();
    cnts("nandi_end", 10, 6);

    // reset in the middle of an sw write
    fd(6'b101011, 6'b000000);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("midrst_before", bus.MemWrite, 1);
    reset = 1'b1;
    #1;
    chk("midrst_strobes", all_out, 0);
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("midrst_fetch", bus.MemRead, 1);
    cnts("midrst", 0, 0);

    // 16 beq at 3 cycles each: both 4-bit counters wrap to 0
    for (int i = 0; i < 16; i++) begin
      fd(6'b000100, 6'b000000);
      if (i == 0) begin
        chk("beq_pcwritecond", bus.PCWriteCond, 1);
        chk("beq_aluop", bus.ALUOp, 2'b01);
      end
      tick();
      if (i == 14) cnts("beq15", 15, 13);
    end
    cnts("beq_wrap", 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
